stream_upsizer: RTL and testbench



---
 rtl/stream_upsizer_pkg.sv | 26 ++
 rtl/stream_upsizer_idle_timer.sv | 31 +++
 rtl/stream_upsizer.sv | 112 +++++++++++
 tb/tb_stream_upsizer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_upsizer_pkg.sv
// Shared types and helpers for the stream upsizer (narrow FIFO beats -> wide words).
// Optional feature macro: STREAM_UPSIZER_TIMEOUT_FLUSH_EN (see stream_upsizer.sv).
package stream_upsizer_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int DEFAULT_RATIO = 4;
    localparam int LANE_IDX_W    = $clog2(DEFAULT_RATIO);
    localparam int MAX_LANES     = 64;

    // Lanes [n-1:0] set; callers truncate to their own lane count.
    function automatic logic [MAX_LANES-1:0] keep_mask(input int n);
        logic [MAX_LANES-1:0] mask;
        mask = '0;
        for (int i = 0; i < MAX_LANES; i++) begin
            if (i < n) begin
                mask[i] = 1'b1;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/stream_upsizer_idle_timer.sv
// Idle counter that saturates at TIMEOUT and flags expiry; only built when
// STREAM_UPSIZER_TIMEOUT_FLUSH_EN is defined.
`ifdef STREAM_UPSIZER_TIMEOUT_FLUSH_EN
module idle_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rstn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] idle_count;

    assign expired = (idle_count == CW'(TIMEOUT));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idle_count <= '0;
        end else if (clear) begin
            idle_count <= '0;
        end else if (enable && !expired) begin
            idle_count <= idle_count + 1'b1;
        end
    end

endmodule
`endif

// File: rtl/stream_upsizer.sv
// Packs RATIO narrow beats from a reg_fifo read port into one wide word.
// Define STREAM_UPSIZER_TIMEOUT_FLUSH_EN to flush partial words after TIMEOUT idle cycles.
module stream_upsizer
    import stream_upsizer_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int RATIO      = DEFAULT_RATIO,
    parameter int TIMEOUT    = 16
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [DATA_WIDTH-1:0]       in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [DATA_WIDTH*RATIO-1:0] out_data,
    output logic [RATIO-1:0]            out_keep,
    output logic                        out_valid,
    input  logic                        out_ready,
    input  logic                        clear,
    output logic [$clog2(RATIO):0]      count
);

    localparam int LANE_W = $clog2(RATIO);
    localparam int CNT_W  = LANE_W + 1;
    localparam int WORD_W = DATA_WIDTH * RATIO;

    state_t           state;
    logic [CNT_W-1:0] count_q;
    logic             in_fire;
    logic             last_beat;
    logic             timeout_hit;

    // While a word is held the next beat may only enter as the word leaves.
    assign in_ready  = rstn && !clear && ((state == FILL) || out_ready);
    assign in_fire   = in_valid && in_ready;
    assign last_beat = (count_q == CNT_W'(RATIO - 1));
    assign count     = count_q;

`ifdef STREAM_UPSIZER_TIMEOUT_FLUSH_EN
    logic idle_clear;

    assign idle_clear = clear || in_fire || (state != FILL) || (count_q == '0);

    idle_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_idle_timer (
        .clk     (clk),
        .rstn    (rstn),
        .clear   (idle_clear),
        .enable  (!idle_clear),
        .expired (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= FILL;
            count_q   <= '0;
            out_data  <= '0;
            out_keep  <= '0;
            out_valid <= 1'b0;
        end else if (clear) begin
            state     <= FILL;
            count_q   <= '0;
            out_data  <= '0;
            out_keep  <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (in_fire) begin
                        // Lane 0 starts a fresh word, so the stale upper lanes are wiped here.
                        if (count_q == '0) begin
                            out_data <= WORD_W'(in_data);
                        end else begin
                            out_data[count_q[LANE_W-1:0]*DATA_WIDTH +: DATA_WIDTH] <= in_data;
                        end
                        count_q <= count_q + 1'b1;
                        if (last_beat) begin
                            state     <= HOLD;
                            out_valid <= 1'b1;
                            out_keep  <= RATIO'(keep_mask(RATIO));
                        end
                    end else if (timeout_hit) begin
                        state     <= HOLD;
                        out_valid <= 1'b1;
                        out_keep  <= RATIO'(keep_mask(int'(count_q)));
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= FILL;
                        out_valid <= 1'b0;
                        out_keep  <= '0;
                        if (in_valid) begin
                            out_data <= WORD_W'(in_data);
                            count_q  <= CNT_W'(1);
                        end else begin
                            count_q <= '0;
                        end
                    end
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stream_upsizer.sv
// Directed and randomized bench for stream_upsizer against a beat-queue reference model.
// Honours STREAM_UPSIZER_TIMEOUT_FLUSH_EN for the partial-flush scenario.
module tb_stream_upsizer;

    localparam int DW      = 8;
    localparam int RATIO   = 4;
    localparam int TIMEOUT = 16;

    logic          clk;
    logic          rstn;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   out_data;
    logic [3:0]    out_keep;
    logic          out_valid;
    logic          out_ready;
    logic          clear;
    logic [2:0]    count;

    int passCount  = 0;
    int failCount  = 0;
    int totalCount = 0;

    stream_upsizer #(
        .DATA_WIDTH (DW),
        .RATIO      (RATIO),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .clear     (clear),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic r, input logic c);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        clear     = c;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Reference model: beats accepted but not yet shipped, oldest first.
    logic [DW-1:0] modelQ[$];
    logic [DW-1:0] wordsSeen[$];
    logic [31:0]   expWord;
    logic [31:0]   gotWords[$];
    logic          expReady;
    logic          sawValid;
    int            held;
    int            accepted;
    int            cycles;
    int            waited;

    initial begin
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        rstn = 1'b0;
        repeat (100) @(negedge clk);
        rstn = 1'b1;
        tick();
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_count", 32'(count), 32'd0);
        checkOutput("reset_out_keep", 32'(out_keep), 32'd0);
        checkOutput("reset_out_data", out_data, 32'd0);

        // Fill one word with the downstream stalled, then hold it.
        applyStimulus(1'b1, 8'h11, 1'b0, 1'b0); tick();
        applyStimulus(1'b1, 8'h22, 1'b0, 1'b0); tick();
        applyStimulus(1'b1, 8'h33, 1'b0, 1'b0); tick();
        applyStimulus(1'b1, 8'h44, 1'b0, 1'b0); tick();
        applyStimulus(1'b1, 8'h99, 1'b0, 1'b0);
        #1;
        checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 10; i++) begin
            checkOutput("hold_out_data", out_data, 32'h44332211);
            checkOutput("hold_out_keep", 32'(out_keep), 32'hF);
            checkOutput("hold_out_valid", 32'(out_valid), 32'd1);
            checkOutput("hold_count", 32'(count), 32'd4);
            tick();
        end

        // Release the word while a new beat arrives in the same cycle.
        applyStimulus(1'b1, 8'h55, 1'b1, 1'b0);
        #1;
        checkOutput("pass_in_ready", 32'(in_ready), 32'd1);
        tick();
        checkOutput("pass_count", 32'(count), 32'd1);
        checkOutput("pass_out_valid", 32'(out_valid), 32'd0);
        checkOutput("pass_out_data", out_data, 32'h00000055);

        // Back-to-back streaming: in_ready must never drop.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 8'(8'h56 + i), 1'b1, 1'b0);
            #1;
            checkOutput("stream_in_ready", 32'(in_ready), 32'd1);
            if (out_valid) gotWords.push_back(out_data);
            tick();
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("stream_word_count", 32'(gotWords.size()), 32'd4);
        if (gotWords.size() == 4) begin
            checkOutput("stream_word0", gotWords[0], 32'h58575655);
            checkOutput("stream_word1", gotWords[1], 32'h5C5B5A59);
            checkOutput("stream_word2", gotWords[2], 32'h605F5E5D);
            checkOutput("stream_word3", gotWords[3], 32'h64636261);
        end
        checkOutput("stream_tail_count", 32'(count), 32'd1);
        checkOutput("stream_tail_data", out_data, 32'h00000065);

        // Clear a partial word, then clear again with a beat on offer.
        applyStimulus(1'b0, '0, 1'b0, 1'b1); tick();
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("clear1_count", 32'(count), 32'd0);
        applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0); tick();
        applyStimulus(1'b1, 8'hBB, 1'b0, 1'b0); tick();
        applyStimulus(1'b1, 8'hCC, 1'b0, 1'b1);
        #1;
        checkOutput("clear2_in_ready", 32'(in_ready), 32'd0);
        tick();
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("clear2_count", 32'(count), 32'd0);
        checkOutput("clear2_out_valid", 32'(out_valid), 32'd0);
        checkOutput("clear2_out_keep", 32'(out_keep), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
            tick();
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("after_clear_word", out_data, 32'h04030201);
        checkOutput("after_clear_valid", 32'(out_valid), 32'd1);

        // Clear wins over an accepting downstream.
        applyStimulus(1'b0, '0, 1'b1, 1'b1); tick();
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("discard_out_valid", 32'(out_valid), 32'd0);
        checkOutput("discard_count", 32'(count), 32'd0);
        checkOutput("discard_out_keep", 32'(out_keep), 32'd0);

        // Asynchronous reset mid-word.
        applyStimulus(1'b1, 8'hE1, 1'b0, 1'b0); tick();
        applyStimulus(1'b1, 8'hE2, 1'b0, 1'b0); tick();
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("midreset_pre_count", 32'(count), 32'd2);
        #2 rstn = 1'b0;
        #1;
        checkOutput("midreset_count", 32'(count), 32'd0);
        checkOutput("midreset_out_data", out_data, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        tick();
        checkOutput("midreset_in_ready", 32'(in_ready), 32'd1);

        // Random stalls on both sides against the beat-queue model.
        $display("[TB] random phase");
        modelQ.delete();
        accepted = 0;
        cycles   = 0;
        while (accepted < 1000 && cycles < 20000) begin
            applyStimulus(($urandom_range(0, 99) < 70), 8'($urandom), ($urandom_range(0, 99) < 60), 1'b0);
            #1;
            held     = modelQ.size();
            expReady = (held < RATIO) || out_ready;
            checkOutput("rand_in_ready", 32'(in_ready), 32'(expReady));
            checkOutput("rand_out_valid", 32'(out_valid), 32'(held == RATIO));
            checkOutput("rand_count", 32'(count), 32'(held));
            if (held == RATIO && out_ready) begin
                expWord = '0;
                for (int k = 0; k < RATIO; k++) expWord[k*DW +: DW] = modelQ[k];
                checkOutput("rand_word", out_data, expWord);
                checkOutput("rand_keep", 32'(out_keep), 32'hF);
                repeat (RATIO) void'(modelQ.pop_front());
            end
            if (in_valid && expReady) begin
                modelQ.push_back(in_data);
                accepted++;
            end
            tick();
            cycles++;
        end
        checkOutput("rand_completed", 32'(accepted >= 1000), 32'd1);

        // Partial word followed by a long idle gap.
        applyStimulus(1'b0, '0, 1'b0, 1'b1); tick();
        applyStimulus(1'b1, 8'h71, 1'b0, 1'b0); tick();
        applyStimulus(1'b1, 8'h72, 1'b0, 1'b0); tick();
        applyStimulus(1'b1, 8'h73, 1'b0, 1'b0); tick();
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
`ifdef STREAM_UPSIZER_TIMEOUT_FLUSH_EN
        waited = 0;
        for (int i = 1; i <= TIMEOUT + 4; i++) begin
            tick();
            if (out_valid) begin
                waited = i;
                break;
            end
        end
        checkOutput("flush_latency_ok", 32'(waited >= TIMEOUT + 1 && waited <= TIMEOUT + 2), 32'd1);
        checkOutput("flush_out_valid", 32'(out_valid), 32'd1);
        checkOutput("flush_out_keep", 32'(out_keep), 32'h7);
        checkOutput("flush_out_data", out_data, 32'h00737271);
        checkOutput("flush_count", 32'(count), 32'd3);
`else
        sawValid = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (out_valid) sawValid = 1'b1;
        end
        checkOutput("noflush_out_valid", 32'(sawValid), 32'd0);
        checkOutput("noflush_count", 32'(count), 32'd3);
        checkOutput("noflush_out_data", out_data, 32'h00737271);
`endif

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
